shift_exec_stage: RTL and testbench

- Registered execute-stage wrapper around the shift datapath of the RISC_KGP ALU. Sits directly downstream of the combinational left/right shifters and upstream of the writeback mux.
- Accepts an operand pair plus shift op through a valid/ready handshake and computes the result combinationally using the same out-of-range rules as the left shifter.
- Adds carry/zero/sign flags and holds results in a 2-entry output buffer, so writeback stalls never drop a result.

---
 rtl/shift_exec_stage.sv | 151 +++++++++++++++
 tb/tb_shift_exec_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_exec_stage.sv
// Registered execute stage for the RISC_KGP shift datapath: computes sll/srl/sra/pass
// with carry/zero/sign flags and queues results in a 2-entry output FIFO.
module shift_exec_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sign
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             zero;
        logic             sign;
    } entry_t;

    logic [4:0]       sh;
    logic [4:0]       neg_sh;
    logic [4:0]       dec_sh;
    logic             b_zero;
    logic             b_le31;
    logic             b_1_32;
    logic [WIDTH-1:0] new_res;
    logic             new_carry;
    entry_t           new_entry;

    // B is a full 32-bit unsigned amount; only B[4:0] drives the barrel shift,
    // the upper bits select the saturated out-of-range results.
    always_comb begin
        sh        = B[4:0];
        neg_sh    = 5'd0 - sh;
        dec_sh    = sh - 5'd1;
        b_zero    = (B == '0);
        b_le31    = (B[WIDTH-1:5] == '0);
        b_1_32    = !b_zero && (b_le31 || (B == WIDTH'(32)));
        new_res   = '0;
        new_carry = 1'b0;
        case (op)
            OP_SLL: begin
                new_res   = b_le31 ? (A << sh) : '0;
                // 32-B wraps to 0 at B==32, so one index covers the whole 1..32 range
                new_carry = b_1_32 ? A[neg_sh] : 1'b0;
            end
            OP_SRL: begin
                new_res   = b_le31 ? (A >> sh) : '0;
                new_carry = b_1_32 ? A[dec_sh] : 1'b0;
            end
            OP_SRA: begin
                new_res   = b_le31 ? $unsigned($signed(A) >>> sh) : {WIDTH{A[WIDTH-1]}};
                new_carry = b_1_32 ? A[dec_sh] : (b_zero ? 1'b0 : A[WIDTH-1]);
            end
            default: begin
                new_res   = A;
                new_carry = 1'b0;
            end
        endcase
        new_entry.res   = new_res;
        new_entry.carry = new_carry;
        new_entry.zero  = (new_res == '0);
        new_entry.sign  = new_res[WIDTH-1];
    end

    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push;
    logic       pop;
    entry_t     head;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = new_entry;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    // Outputs are forced to zero while empty so stale entries never leak out.
    assign head   = mem_q[rd_ptr_q];
    assign result = out_valid ? head.res   : '0;
    assign carry  = out_valid ? head.carry : 1'b0;
    assign zero   = out_valid ? head.zero  : 1'b0;
    assign sign   = out_valid ? head.sign  : 1'b0;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: driver pushes hand-computed expectations on
// accept, a negedge monitor pops and compares on every output handshake.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        sign;

    shift_exec_stage #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] r;
        logic        c;
    } vec_t;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        s;
    } exp_t;

    vec_t vecs [16];
    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.r = vecs[idx].r;
        e.c = vecs[idx].c;
        e.z = (vecs[idx].r == 32'd0);
        e.s = vecs[idx].r[31];
        exp_q.push_back(e);
    endtask

    // Drive a bundle and hold it until accepted; in_valid stays high on return.
    task automatic send(input int idx, output int waits);
        @(posedge clk);
        #1;
        A        = vecs[idx].a;
        B        = vecs[idx].b;
        op       = vecs[idx].op;
        in_valid = 1'b1;
        waits    = 0;
        forever begin
            @(negedge clk);
            if (in_ready && !flush) begin
                push_exp(idx);
                $display("push vec%0d A=%h B=%h op=%0d", idx, vecs[idx].a, vecs[idx].b, vecs[idx].op);
                break;
            end
            waits++;
            if (waits > 20) begin
                total++;
                bad++;
                $display("FAIL send_timeout: vec%0d not accepted after %0d cycles, required acceptance", idx, waits);
                break;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got result=%h, expected no output", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("pop result=%h carry=%b zero=%b sign=%b", result, carry, zero, sign);
                check("result", result, e.r);
                check("flags_czs", {29'd0, carry, zero, sign}, {29'd0, e.c, e.z, e.s});
            end
        end
    end

    initial begin
        int w;
        vecs[0]  = '{32'h0000_00F1, 32'd4,  2'b00, 32'h0000_0F10, 1'b0};
        vecs[1]  = '{32'h8000_0001, 32'd1,  2'b00, 32'h0000_0002, 1'b1};
        vecs[2]  = '{32'h8000_0001, 32'd32, 2'b00, 32'h0000_0000, 1'b1};
        vecs[3]  = '{32'h8000_0001, 32'd40, 2'b00, 32'h0000_0000, 1'b0};
        vecs[4]  = '{32'h8000_0000, 32'd40, 2'b10, 32'hFFFF_FFFF, 1'b1};
        vecs[5]  = '{32'h8000_0000, 32'd31, 2'b01, 32'h0000_0001, 1'b0};
        vecs[6]  = '{32'h1234_5678, 32'd0,  2'b00, 32'h1234_5678, 1'b0};
        vecs[7]  = '{32'h0000_00F0, 32'd5,  2'b01, 32'h0000_0007, 1'b1};
        vecs[8]  = '{32'hF000_0000, 32'd4,  2'b10, 32'hFF00_0000, 1'b0};
        vecs[9]  = '{32'hDEAD_BEEF, 32'd7,  2'b11, 32'hDEAD_BEEF, 1'b0};
        vecs[10] = '{32'h8000_0000, 32'd32, 2'b01, 32'h0000_0000, 1'b1};
        vecs[11] = '{32'h7FFF_FFFF, 32'd33, 2'b10, 32'h0000_0000, 1'b0};
        vecs[12] = '{32'h0000_0003, 32'd1,  2'b01, 32'h0000_0001, 1'b1};
        vecs[13] = '{32'h8000_0000, 32'd1,  2'b10, 32'hC000_0000, 1'b0};
        vecs[14] = '{32'h0000_0001, 32'd31, 2'b00, 32'h8000_0000, 1'b0};
        vecs[15] = '{32'h0000_0003, 32'd31, 2'b00, 32'h8000_0000, 1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        op        = 2'b00;
        out_ready = 1'b0;

        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags", {29'd0, carry, zero, sign}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op latency
        out_ready = 1'b1;
        send(0, w);
        idle();
        @(negedge clk);
        check("single_out_valid_next", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("single_out_valid_after", 32'(out_valid), 32'd0);

        // Streaming push/pop at count 1: one result per cycle, no bubbles
        for (int i = 1; i < 16; i++) begin
            send(i, w);
            check("stream_no_stall", 32'(w), 32'd0);
            if (i > 1) check("stream_no_bubble", 32'(out_valid), 32'd1);
        end
        idle();
        wait_empty();

        // Backpressure: two accepted, third held until the first pop
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(1, w);
        send(2, w);
        check("bp_second_accepted", 32'(w), 32'd0);
        @(posedge clk);
        #1;
        A  = vecs[3].a;
        B  = vecs[3].b;
        op = vecs[3].op;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            check("bp_head_stable", result, vecs[1].r);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_before_pop", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        if (in_ready) push_exp(3);
        idle();
        wait_empty();

        // Flush with two buffered and a bundle offered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4, w);
        send(5, w);
        @(posedge clk);
        #1;
        A        = vecs[6].a;
        B        = vecs[6].b;
        op       = vecs[6].op;
        in_valid = 1'b1;
        flush    = 1'b1;
        idle();
        exp_q.delete();
        @(negedge clk);
        check("flush2_out_valid", 32'(out_valid), 32'd0);
        check("flush2_in_ready", 32'(in_ready), 32'd1);
        check("flush2_result", result, 32'd0);

        // Flush at count 1 while a push would otherwise be accepted
        send(7, w);
        idle();
        @(posedge clk);
        #1;
        A        = vecs[8].a;
        B        = vecs[8].b;
        op       = vecs[8].op;
        in_valid = 1'b1;
        flush    = 1'b1;
        idle();
        exp_q.delete();
        @(negedge clk);
        check("flush1_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(9, w);
        idle();
        wait_empty();

        // Asynchronous reset mid-cycle with two buffered
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(13, w);
        send(14, w);
        idle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("areset_out_valid", 32'(out_valid), 32'd0);
        check("areset_in_ready", 32'(in_ready), 32'd1);
        check("areset_result", result, 32'd0);
        check("areset_flags", {29'd0, carry, zero, sign}, 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_out_valid", 32'(out_valid), 32'd0);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(15, w);
        idle();
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
